dma_channel_scheduler: RTL and testbench

- Round-robin burst scheduler that shares one direction's channel FSM (read or write) among NUM_CH DMA channels.
- Holds a remaining-beat count per channel and slices each transfer into bursts of at most MAX_BEATS.
- Presents one burst at a time to the channel FSM, and reports per-channel and all-channel completion.
- Instantiated twice in the DMA top: once for the read side, once for the write side.

---
 rtl/dma_channel_scheduler_if.sv | 28 ++
 rtl/dma_channel_scheduler.sv | 160 ++++++++++++++++
 tb/tb_dma_channel_scheduler.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dma_channel_scheduler_if.sv
// Burst offer/accept handshake between the scheduler and one direction's channel FSM.
interface dma_channel_scheduler_if #(
    parameter int NUM_CH = 4
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic            arbValid;
    logic [8:0]      arbBeats;
    logic [CH_W-1:0] arbChannel;
    logic            arbReady;
    logic            arbDone;

    modport master (
        output arbValid,
        output arbBeats,
        output arbChannel,
        input  arbReady,
        input  arbDone
    );

    modport slave (
        input  arbValid,
        input  arbBeats,
        input  arbChannel,
        output arbReady,
        output arbDone
    );
endinterface

// File: rtl/dma_channel_scheduler.sv
// Round-robin burst scheduler: slices per-channel beat counts into bursts of at
// most MAX_BEATS and offers them one at a time to a shared channel FSM.
//   state   | meaning
//   S_IDLE  | waiting for arbitrate with at least one active channel
//   S_PICK  | round-robin grant and burst sizing
//   S_ISSUE | burst offered, waiting for arbReady
//   S_WAIT  | burst accepted, waiting for arbDone
module dma_channel_scheduler #(
    parameter int  NUM_CH    = 4,
    parameter int  CNT_W     = 16,
    parameter int  MAX_BEATS = 256,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    AXI_aclk,
    input  logic                    AXI_areset,
    input  logic                    load_valid,
    input  logic [CH_W-1:0]         load_ch,
    input  logic [CNT_W-1:0]        load_beats,
    input  logic                    arbitrate,
    dma_channel_scheduler_if.master arb,
    output logic                    channelDone,
    output logic [CH_W-1:0]         doneChannel,
    output logic                    transactionsDone,
    output logic                    validChannels,
    output logic [31:0]             activeChannels
);
    localparam int CH_SLOTS = 1 << CH_W;
    // Channel codes at or above NUM_CH are unreachable and must never load.
    localparam logic [CH_SLOTS-1:0] CH_EXISTS = CH_SLOTS'((64'd1 << NUM_CH) - 64'd1);

    typedef enum logic [1:0] {S_IDLE, S_PICK, S_ISSUE, S_WAIT} state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [CNT_W-1:0]    r_rem [NUM_CH];
    logic [NUM_CH-1:0]   r_active;
    logic [CH_W-1:0]     r_rr_ptr;
    logic [CH_W-1:0]     r_grant;
    logic [8:0]          r_burst;
    logic                r_channel_done;
    logic [CH_W-1:0]     r_done_ch;
    logic                r_txn_done;

    logic [CH_SLOTS-1:0] w_active_pad;
    logic                w_load_ok;
    logic [NUM_CH-1:0]   w_load_mask;
    logic                w_found;
    logic [CH_W-1:0]     w_pick;
    logic [31:0]         w_pick_rem;
    logic [8:0]          w_pick_burst;
    logic                w_burst_done;
    logic [CNT_W-1:0]    w_rem_next;
    logic                w_rem_zero;
    logic [NUM_CH-1:0]   w_active_after;

    assign w_active_pad = CH_SLOTS'(r_active);
    assign w_load_ok    = load_valid && (load_beats != '0) && CH_EXISTS[load_ch] && !w_active_pad[load_ch];

    always_comb begin
        w_load_mask = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_load_mask[i] = w_load_ok && (int'(load_ch) == i);
        end
    end

    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            if (!w_found && r_active[(int'(r_rr_ptr) + k) % NUM_CH]) begin
                w_found = 1'b1;
                w_pick  = CH_W'((int'(r_rr_ptr) + k) % NUM_CH);
            end
        end
    end

    always_comb begin
        w_pick_rem = 32'(r_rem[w_pick]);
        if (w_pick_rem > 32'(MAX_BEATS)) begin
            w_pick_burst = 9'(MAX_BEATS);
        end else begin
            w_pick_burst = 9'(w_pick_rem);
        end
    end

    assign w_burst_done = (r_state == S_WAIT) && arb.arbDone;
    assign w_rem_next   = r_rem[r_grant] - CNT_W'(r_burst);
    assign w_rem_zero   = (w_rem_next == '0);

    // Same-cycle loads count as still active when deciding PICK versus IDLE.
    always_comb begin
        w_active_after = r_active | w_load_mask;
        if (w_rem_zero) begin
            w_active_after[r_grant] = 1'b0;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (arbitrate && validChannels) w_state_next = S_PICK;
            S_PICK:  w_state_next = w_found ? S_ISSUE : S_IDLE;
            S_ISSUE: if (arb.arbReady) w_state_next = S_WAIT;
            S_WAIT:  if (arb.arbDone) w_state_next = (|w_active_after) ? S_PICK : S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge AXI_aclk) begin
        if (AXI_areset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge AXI_aclk) begin
        if (AXI_areset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_rem[i] <= '0;
            end
            r_active       <= '0;
            r_rr_ptr       <= CH_W'(NUM_CH - 1);
            r_grant        <= '0;
            r_burst        <= '0;
            r_channel_done <= 1'b0;
            r_done_ch      <= '0;
            r_txn_done     <= 1'b0;
        end else begin
            r_channel_done <= 1'b0;
            r_txn_done     <= 1'b0;
            r_active       <= w_burst_done ? w_active_after : (r_active | w_load_mask);
            if (w_load_ok) begin
                r_rem[load_ch] <= load_beats;
            end
            if ((r_state == S_PICK) && w_found) begin
                r_grant <= w_pick;
                r_burst <= w_pick_burst;
            end
            if (w_burst_done) begin
                r_rem[r_grant] <= w_rem_next;
                r_rr_ptr       <= r_grant;
                if (w_rem_zero) begin
                    r_channel_done <= 1'b1;
                    r_done_ch      <= r_grant;
                    r_txn_done     <= ~|w_active_after;
                end
            end
        end
    end

    assign arb.arbValid    = (r_state == S_ISSUE);
    assign arb.arbBeats    = (r_state == S_ISSUE) ? r_burst : '0;
    assign arb.arbChannel  = (r_state == S_ISSUE) ? r_grant : '0;
    assign channelDone      = r_channel_done;
    assign doneChannel      = r_done_ch;
    assign transactionsDone = r_txn_done;
    assign validChannels    = |r_active;
    assign activeChannels   = 32'(r_active);
endmodule

// File: tb/tb_dma_channel_scheduler.sv
// Self-checking bench: vector table of load sets with expected burst/done order,
// plus hand sequences for illegal loads, mid-run loads and reset mid-burst.
module tb_dma_channel_scheduler;
    localparam int NUM_CH    = 4;
    localparam int CNT_W     = 16;
    localparam int MAX_BEATS = 256;
    localparam int CH_W      = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             load_valid;
    logic [CH_W-1:0]  load_ch;
    logic [CNT_W-1:0] load_beats;
    logic             arbitrate;
    logic             channelDone;
    logic [CH_W-1:0]  doneChannel;
    logic             transactionsDone;
    logic             validChannels;
    logic [31:0]      activeChannels;

    dma_channel_scheduler_if #(.NUM_CH(NUM_CH)) arb_if ();

    dma_channel_scheduler #(
        .NUM_CH    (NUM_CH),
        .CNT_W     (CNT_W),
        .MAX_BEATS (MAX_BEATS)
    ) dut (
        .AXI_aclk         (clk),
        .AXI_areset       (rst),
        .load_valid       (load_valid),
        .load_ch          (load_ch),
        .load_beats       (load_beats),
        .arbitrate        (arbitrate),
        .arb              (arb_if),
        .channelDone      (channelDone),
        .doneChannel      (doneChannel),
        .transactionsDone (transactionsDone),
        .validChannels    (validChannels),
        .activeChannels   (activeChannels)
    );

    always #5 clk = ~clk;

    typedef struct {
        int ch;
        int beats;
    } burst_t;

    typedef struct {
        int beats [NUM_CH];
        int bp;
        int nb;
        int bch [6];
        int bbt [6];
        int nd;
        int dch [NUM_CH];
    } vec_t;

    burst_t exp_bursts [$];
    int     exp_done [$];
    vec_t   vecs [5];
    int     errors   = 0;
    int     checks   = 0;
    int     txn_seen = 0;

    function automatic void chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endfunction

    function automatic void fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event not expected / not seen", name);
    endfunction

    // Every clock step goes through here so done pulses are never missed.
    task automatic tick();
        @(posedge clk);
        #1;
        if (channelDone) begin
            if (exp_done.size() == 0) fail("unexpected_channelDone");
            else chk("doneChannel", int'(doneChannel), exp_done.pop_front());
        end
        if (transactionsDone) begin
            txn_seen++;
            chk("txn_with_channelDone", int'(channelDone), 1);
            chk("txn_dones_outstanding", exp_done.size(), 0);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic load(input int ch, input int beats);
        load_valid = 1'b1;
        load_ch    = CH_W'(ch);
        load_beats = CNT_W'(beats);
        tick();
        load_valid = 1'b0;
    endtask

    task automatic push_burst(input int ch, input int beats);
        burst_t b;
        b.ch    = ch;
        b.beats = beats;
        exp_bursts.push_back(b);
    endtask

    task automatic start_arb();
        arbitrate = 1'b1;
        tick();
        arbitrate = 1'b0;
        chk("latency_n1_arbValid", int'(arb_if.arbValid), 0);
        tick();
        chk("latency_n2_arbValid", int'(arb_if.arbValid), 1);
    endtask

    task automatic serve_burst(input int bp, input int inj_ch, input int inj_beats);
        burst_t e;
        int     waited;
        e.ch    = -1;
        e.beats = -1;
        waited  = 0;
        while (!arb_if.arbValid && waited < 20) begin
            tick();
            waited++;
        end
        if (!arb_if.arbValid) begin
            fail("arbValid_timeout");
            return;
        end
        if (exp_bursts.size() == 0) fail("unexpected_burst");
        else e = exp_bursts.pop_front();
        chk("arbChannel", int'(arb_if.arbChannel), e.ch);
        chk("arbBeats", int'(arb_if.arbBeats), e.beats);
        for (int i = 0; i < bp; i++) begin
            tick();
            chk("bp_arbValid", int'(arb_if.arbValid), 1);
            chk("bp_arbBeats", int'(arb_if.arbBeats), e.beats);
            chk("bp_arbChannel", int'(arb_if.arbChannel), e.ch);
        end
        arb_if.arbReady = 1'b1;
        tick();
        arb_if.arbReady = 1'b0;
        chk("arbValid_after_accept", int'(arb_if.arbValid), 0);
        if (inj_beats > 0) begin
            load_valid = 1'b1;
            load_ch    = CH_W'(inj_ch);
            load_beats = CNT_W'(inj_beats);
        end
        tick();
        load_valid = 1'b0;
        if (inj_beats > 0) chk("validChannels_during_wait", int'(validChannels), 1);
        tick();
        arb_if.arbDone = 1'b1;
        tick();
        arb_if.arbDone = 1'b0;
    endtask

    task automatic end_checks();
        tick();
        tick();
        chk("bursts_outstanding", exp_bursts.size(), 0);
        chk("dones_outstanding", exp_done.size(), 0);
        chk("transactionsDone_count", txn_seen, 1);
        chk("idle_arbValid", int'(arb_if.arbValid), 0);
        chk("end_activeChannels", int'(activeChannels), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int mask;
        rst             = 1'b1;
        load_valid      = 1'b0;
        load_ch         = '0;
        load_beats      = '0;
        arbitrate       = 1'b0;
        arb_if.arbReady = 1'b0;
        arb_if.arbDone  = 1'b0;

        vecs[0].beats = '{600, 0, 0, 0};  vecs[0].bp = 5; vecs[0].nb = 3;
        vecs[0].bch   = '{0, 0, 0, 0, 0, 0};
        vecs[0].bbt   = '{256, 256, 88, 0, 0, 0};
        vecs[0].nd    = 1; vecs[0].dch = '{0, 0, 0, 0};

        vecs[1].beats = '{300, 0, 10, 256}; vecs[1].bp = 0; vecs[1].nb = 4;
        vecs[1].bch   = '{0, 2, 3, 0, 0, 0};
        vecs[1].bbt   = '{256, 10, 256, 44, 0, 0};
        vecs[1].nd    = 3; vecs[1].dch = '{2, 3, 0, 0};

        vecs[2].beats = '{0, 1, 0, 257};  vecs[2].bp = 0; vecs[2].nb = 3;
        vecs[2].bch   = '{1, 3, 3, 0, 0, 0};
        vecs[2].bbt   = '{1, 256, 1, 0, 0, 0};
        vecs[2].nd    = 2; vecs[2].dch = '{1, 3, 0, 0};

        vecs[3].beats = '{5, 5, 5, 5};    vecs[3].bp = 0; vecs[3].nb = 4;
        vecs[3].bch   = '{0, 1, 2, 3, 0, 0};
        vecs[3].bbt   = '{5, 5, 5, 5, 0, 0};
        vecs[3].nd    = 4; vecs[3].dch = '{0, 1, 2, 3};

        vecs[4].beats = '{0, 256, 512, 0}; vecs[4].bp = 1; vecs[4].nb = 3;
        vecs[4].bch   = '{1, 2, 2, 0, 0, 0};
        vecs[4].bbt   = '{256, 256, 256, 0, 0, 0};
        vecs[4].nd    = 2; vecs[4].dch = '{1, 2, 0, 0};

        for (int v = 0; v < 5; v++) begin
            do_reset();
            chk("reset_activeChannels", int'(activeChannels), 0);
            chk("reset_validChannels", int'(validChannels), 0);
            chk("reset_arbValid", int'(arb_if.arbValid), 0);
            chk("reset_channelDone", int'(channelDone), 0);
            mask = 0;
            for (int c = 0; c < NUM_CH; c++) begin
                if (vecs[v].beats[c] > 0) begin
                    load(c, vecs[v].beats[c]);
                    mask = mask | (1 << c);
                end
            end
            chk("loaded_activeChannels", int'(activeChannels), mask);
            chk("loaded_validChannels", int'(validChannels), 1);
            for (int b = 0; b < vecs[v].nb; b++) push_burst(vecs[v].bch[b], vecs[v].bbt[b]);
            for (int d = 0; d < vecs[v].nd; d++) exp_done.push_back(vecs[v].dch[d]);
            txn_seen = 0;
            start_arb();
            for (int b = 0; b < vecs[v].nb; b++) serve_burst(vecs[v].bp, 0, 0);
            end_checks();
        end

        // Illegal loads and arbitrate with nothing active.
        do_reset();
        load(1, 0);
        chk("zero_load_ignored", int'(activeChannels), 0);
        arbitrate = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("arbitrate_empty_arbValid", int'(arb_if.arbValid), 0);
        end
        arbitrate = 1'b0;
        load(0, 100);
        load(0, 50);
        chk("reload_activeChannels", int'(activeChannels), 1);
        push_burst(0, 100);
        exp_done.push_back(0);
        txn_seen = 0;
        start_arb();
        serve_burst(0, 0, 0);
        end_checks();

        // Load arriving while a burst is outstanding wins the next grant.
        do_reset();
        load(0, 300);
        push_burst(0, 256);
        push_burst(1, 4);
        push_burst(0, 44);
        exp_done.push_back(1);
        exp_done.push_back(0);
        txn_seen = 0;
        start_arb();
        serve_burst(0, 1, 4);
        chk("validChannels_after_inject", int'(validChannels), 1);
        serve_burst(0, 0, 0);
        serve_burst(0, 0, 0);
        end_checks();

        // Reset while in WAIT abandons the burst silently.
        do_reset();
        load(2, 50);
        start_arb();
        arb_if.arbReady = 1'b1;
        tick();
        arb_if.arbReady = 1'b0;
        chk("wait_arbValid", int'(arb_if.arbValid), 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midreset_arbValid", int'(arb_if.arbValid), 0);
        chk("midreset_arbBeats", int'(arb_if.arbBeats), 0);
        chk("midreset_arbChannel", int'(arb_if.arbChannel), 0);
        chk("midreset_activeChannels", int'(activeChannels), 0);
        chk("midreset_validChannels", int'(validChannels), 0);
        chk("midreset_channelDone", int'(channelDone), 0);
        chk("midreset_transactionsDone", int'(transactionsDone), 0);
        arb_if.arbDone = 1'b1;
        tick();
        arb_if.arbDone = 1'b0;
        chk("stray_arbDone_channelDone", int'(channelDone), 0);
        load(3, 1);
        push_burst(3, 1);
        exp_done.push_back(3);
        txn_seen = 0;
        start_arb();
        serve_burst(0, 0, 0);
        end_checks();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
